// File: rtl/inst_buffer_pkg.sv
// Shared types for the fetch-to-decode instruction buffer: the IF/ID packet
// and the payload view of it that the buffer actually stores.
package inst_buffer_pkg;

    localparam int INST_BUF_DEPTH = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
    } IF_ID_PACKET;

    // Everything below the valid bit; a stored entry is valid by construction.
    localparam int PAYLOAD_W = $bits(IF_ID_PACKET) - 1;
    typedef logic [PAYLOAD_W-1:0] payload_t;

    function automatic payload_t strip_valid(input IF_ID_PACKET pkt);
        return pkt[PAYLOAD_W-1:0];
    endfunction

    function automatic IF_ID_PACKET with_valid(input payload_t payload);
        return {1'b1, payload};
    endfunction

endpackage

// File: rtl/inst_buffer_fifo_ptr.sv
// Generic FIFO bookkeeping: wrapping read/write pointers plus occupancy count.
// Reusable for any power-of-two circular queue (LSQ, ROB).
module inst_buffer_fifo_ptr #(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W:0]   count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

endmodule

// File: rtl/inst_buffer.sv
// Registered FIFO between fetch and decode, flushed by squash.
// Define INST_BUF_BYPASS_EN to let an empty buffer pass fetch straight through.
module inst_buffer
    import inst_buffer_pkg::*;
#(
    parameter  int DEPTH = INST_BUF_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           squash,
    input  IF_ID_PACKET    if_packet_in,
    output logic           in_ready,
    output IF_ID_PACKET    id_packet_out,
    input  logic           out_ready,
    output logic [PTR_W:0] count
);

    payload_t         mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             full;
    logic             empty;
    logic             enq;
    logic             deq;
    logic             wr_en;

    assign in_ready = ~full;
    assign enq      = if_packet_in.valid & in_ready & ~squash;

    // NOTE: the default assignment up front keeps this always_comb latch-free.
    always_comb begin
        id_packet_out = '0;
        if (!squash) begin
            if (!empty) begin
                id_packet_out = with_valid(mem[head]);
            end
`ifdef INST_BUF_BYPASS_EN
            else if (if_packet_in.valid) begin
                id_packet_out = if_packet_in;
            end
`endif
        end
    end

    assign deq = id_packet_out.valid & out_ready;

    // A bypassed packet consumed while empty never needs to land in storage.
    assign wr_en = enq & ~(empty & deq);

    // NOTE: storage has no reset; the occupancy count alone decides which
    // entries are live, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (wr_en) mem[tail] <= strip_valid(if_packet_in);
    end

    inst_buffer_fifo_ptr #(
        .DEPTH (DEPTH)
    ) u_ptr (
        .clock  (clock),
        .reset  (reset),
        .clear  (squash),
        .push   (enq),
        .pop    (deq),
        .wr_ptr (tail),
        .rd_ptr (head),
        .count  (count),
        .full   (full),
        .empty  (empty)
    );

endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer against a queue-based reference model;
// expectations follow INST_BUF_BYPASS_EN when the macro is defined.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int DEPTH = 8;
`ifdef INST_BUF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic        out_ready;
    logic        in_ready;
    logic [3:0]  count;
    IF_ID_PACKET if_packet_in;
    IF_ID_PACKET id_packet_out;

    inst_buffer #(.DEPTH(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .squash        (squash),
        .if_packet_in  (if_packet_in),
        .in_ready      (in_ready),
        .id_packet_out (id_packet_out),
        .out_ready     (out_ready),
        .count         (count)
    );

    always #5 clock = ~clock;

    // Reference model: the buffer is simply an ordered list of packets.
    IF_ID_PACKET q[$];
    IF_ID_PACKET exp_pkt;
    int          exp_count;
    logic        exp_ready;
    logic        exp_valid;
    logic        m_bypass;
    logic        m_acc;
    int          errors = 0;
    int          checks = 0;

    function automatic IF_ID_PACKET mk(input logic v, input logic [31:0] pc);
        IF_ID_PACKET p;
        p.valid = v;
        p.inst  = {pc[15:0], ~pc[15:0]};
        p.pc    = pc;
        p.npc   = pc + 32'd4;
        return p;
    endfunction

    // Apply inputs mid-cycle and compute what the outputs must be now.
    task automatic drive(input logic v, input logic [31:0] pc, input logic ordy,
                         input logic sq, input logic rst);
        @(negedge clock);
        if_packet_in = mk(v, pc);
        out_ready    = ordy;
        squash       = sq;
        reset        = rst;
        #1;
        exp_ready = (q.size() < DEPTH);
        m_bypass  = BYP && !rst && q.size() == 0 && v && !sq;
        exp_valid = !sq && (q.size() > 0 || m_bypass);
        exp_pkt   = '0;
        if (exp_valid) exp_pkt = (q.size() > 0) ? q[0] : if_packet_in;
        exp_count = q.size();
    endtask

    // Advance the model by the rules of the buffer, then take the clock edge.
    task automatic tick();
        m_acc = !reset && !squash && if_packet_in.valid && exp_ready;
        if (reset || squash) begin
            q.delete();
        end else if (!(m_bypass && exp_valid && out_ready)) begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (m_acc) q.push_back(if_packet_in);
        end
        @(posedge clock);
    endtask

    task automatic do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1 || id_packet_out !== '0) begin
            errors++;
            $display("FAIL reset_state: got count=%0d in_ready=%b out=%h, want count=0 in_ready=1 out=0",
                     count, in_ready, id_packet_out);
        end
        tick();
    endtask

    task automatic test_basic();
        logic        tv [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
        logic [31:0] tp [8] = '{32'h0, 32'h4, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        logic        tr [8] = '{0, 0, 0, 0, 1, 1, 1, 0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(tv[i], tp[i], tr[i], 1'b0, 1'b0);
            checks++;
            if (id_packet_out !== exp_pkt || count !== 4'(exp_count) || in_ready !== exp_ready) begin
                errors++;
                $display("FAIL basic cyc=%0d: got out=%h cnt=%0d rdy=%b, want out=%h cnt=%0d rdy=%b",
                         i, id_packet_out, count, in_ready, exp_pkt, exp_count, exp_ready);
            end
            if (i == 3) begin
                checks++;
                if (count !== 4'd3 || id_packet_out.pc !== 32'h0 || id_packet_out.valid !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_three: got count=%0d pc=%h v=%b, want count=3 pc=0 v=1",
                             count, id_packet_out.pc, id_packet_out.valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        do_reset();
        // 8 fills, 0x20 held twice while full, one dequeue, then 0x20 accepted.
        for (int i = 0; i < 13; i++) begin
            logic [31:0] pc   = (i < 8) ? 32'h200 + 32'(4 * i) : 32'h20;
            logic        v    = (i < 12);
            logic        ordy = (i == 10);
            if (m_acc && i == 12) v = 1'b0;
            drive(v, pc, ordy, 1'b0, 1'b0);
            checks++;
            if (id_packet_out !== exp_pkt || count !== 4'(exp_count) || in_ready !== exp_ready) begin
                errors++;
                $display("FAIL full cyc=%0d: got out=%h cnt=%0d rdy=%b, want out=%h cnt=%0d rdy=%b",
                         i, id_packet_out, count, in_ready, exp_pkt, exp_count, exp_ready);
            end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd8 || in_ready !== 1'b0 || q[DEPTH-1].pc !== 32'h20) begin
            errors++;
            $display("FAIL full_hold: got count=%0d in_ready=%b, want count=8 in_ready=0 with 0x20 last",
                     count, in_ready);
        end
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (id_packet_out !== exp_pkt || count !== 4'(exp_count)) begin
                errors++;
                $display("FAIL full_drain cyc=%0d: got out=%h cnt=%0d, want out=%h cnt=%0d",
                         i, id_packet_out, count, exp_pkt, exp_count);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), (i >= 4), 1'b0, 1'b0);
            checks++;
            if (id_packet_out !== exp_pkt || count !== 4'(exp_count) || in_ready !== exp_ready) begin
                errors++;
                $display("FAIL stream cyc=%0d: got out=%h cnt=%0d rdy=%b, want out=%h cnt=%0d rdy=%b",
                         i, id_packet_out, count, in_ready, exp_pkt, exp_count, exp_ready);
            end
            if (i >= 4) begin
                checks++;
                if (count !== 4'd4 || id_packet_out.pc !== 32'h300 + 32'(4 * (i - 4))) begin
                    errors++;
                    $display("FAIL stream_seq cyc=%0d: got count=%0d pc=%h, want count=4 pc=%h",
                             i, count, id_packet_out.pc, 32'h300 + 32'(4 * (i - 4)));
                end
            end
            tick();
        end
    endtask

    task automatic test_squash();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h500, 1'b1, 1'b1, 1'b0);
        checks++;
        if (id_packet_out.valid !== 1'b0 || count !== 4'd5 || id_packet_out !== exp_pkt) begin
            errors++;
            $display("FAIL squash_cycle: got valid=%b count=%0d, want valid=0 count=5",
                     id_packet_out.valid, count);
        end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd0 || id_packet_out.valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL squash_after: got count=%0d valid=%b in_ready=%b, want 0 0 1",
                     count, id_packet_out.valid, in_ready);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h600 + 32'(4 * i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h700, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd0 || in_ready !== 1'b1 || id_packet_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d in_ready=%b valid=%b, want 0 1 0",
                     count, in_ready, id_packet_out.valid);
        end
        tick();
        drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (id_packet_out.pc !== 32'h100 || id_packet_out.valid !== 1'b1 || id_packet_out !== exp_pkt) begin
            errors++;
            $display("FAIL reset_first: got pc=%h valid=%b, want pc=100 valid=1",
                     id_packet_out.pc, id_packet_out.valid);
        end
        tick();
    endtask

    task automatic test_latency();
        do_reset();
        drive(1'b1, 32'h40, 1'b1, 1'b0, 1'b0);
        checks++;
        if (id_packet_out.valid !== BYP || id_packet_out !== exp_pkt) begin
            errors++;
            $display("FAIL latency_same: got out=%h, want out=%h", id_packet_out, exp_pkt);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== (BYP ? 4'd0 : 4'd1) || id_packet_out !== exp_pkt) begin
            errors++;
            $display("FAIL latency_next: got count=%0d out=%h, want count=%0d out=%h",
                     count, id_packet_out, BYP ? 0 : 1, exp_pkt);
        end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (count !== 4'd0 || id_packet_out.valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_drain: got count=%0d valid=%b, want 0 0",
                     count, id_packet_out.valid);
        end
        tick();
    endtask

    task automatic test_random();
        logic        hv      = 1'b0;
        logic [31:0] hpc     = 32'h0;
        logic [31:0] pc_next = 32'h1000;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!hv) begin
                hv  = ($urandom_range(3) != 0);
                hpc = pc_next;
            end
            drive(hv, hpc, 1'($urandom_range(2) == 0), 1'($urandom_range(23) == 0), 1'b0);
            checks++;
            if (id_packet_out !== exp_pkt || count !== 4'(exp_count) || in_ready !== exp_ready) begin
                errors++;
                $display("FAIL random cyc=%0d: got out=%h cnt=%0d rdy=%b, want out=%h cnt=%0d rdy=%b",
                         i, id_packet_out, count, in_ready, exp_pkt, exp_count, exp_ready);
            end
            tick();
            if (m_acc) begin
                hv      = 1'b0;
                pc_next = pc_next + 32'd4;
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        squash       = 1'b0;
        out_ready    = 1'b0;
        if_packet_in = '0;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_squash();
        test_reset_mid();
        test_latency();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_buffer.md
Name: inst_buffer

Overview:
- Registered FIFO between the fetch stage and the decoder. Buffers IF_ID_PACKET entries so fetch keeps running while decode/dispatch stalls.
- Presents the oldest entry to the decoder with valid forced consistent with occupancy.
- Squashes all contents on branch mispredict or other pipeline flush.

Parameters:
- DEPTH, 8, number of entries; power of two, >= 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; empties buffer.
- squash  input  1  flush all entries this cycle (mispredict/exception).
- if_packet_in  input  IF_ID_PACKET  packet from fetch; .valid = enqueue request.
- in_ready  output  1  buffer can accept; = ~full (registered state only, no comb path from out_ready).
- id_packet_out  output  IF_ID_PACKET  head entry to decoder; .valid = ~empty & ~squash.
- out_ready  input  1  downstream (dispatch) accepts head this cycle.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high (reset).
- Storage: DEPTH-entry array of IF_ID_PACKET, head/tail pointers PTR_W bits, occupancy counter PTR_W+1 bits. Pointers wrap modulo DEPTH.
- Reset values: head=0, tail=0, count=0, in_ready=1, id_packet_out.valid=0. Other id_packet_out fields are don't-care when valid=0; drive 0.
- Enqueue: enq = if_packet_in.valid & in_ready & ~squash. Writes at tail, tail+1 at next edge.
- Dequeue: deq = id_packet_out.valid & out_ready. Head advances at next edge.
- Simultaneous enq & deq: count unchanged, both pointers advance. Legal when full (only if in_ready=1, which it is not) and when empty (bypass case, see optional feature).
- Full: count==DEPTH. in_ready=0; if_packet_in ignored; fetch must hold. Enqueue is not allowed in the same cycle as a dequeue while full.
- Empty: count==0. id_packet_out.valid=0; out_ready ignored.
- Latency (no bypass): packet enqueued in cycle N is visible at the output in cycle N+1 at the earliest.
- squash: highest priority after reset.
  - Next edge: head=tail=0 and count=0.
  - enq and deq are both suppressed that cycle.
  - id_packet_out.valid is forced 0 combinationally in the squash cycle.
- reset mid-operation: identical to squash; contents are discarded.
- Ordering: strict FIFO; no reordering and no duplication.
- The .valid bit of each stored entry is stored as 1. Output valid derives from occupancy, never from a stale stored bit.

Optional Feature:
- INST_BUF_BYPASS_EN defined:
  - When count==0, if_packet_in.valid=1 and squash=0, id_packet_out = if_packet_in combinationally, with valid=1.
  - If out_ready=1 that cycle, the packet is consumed and nothing is written (count stays 0).
  - Otherwise it is written normally.
  - Zero-cycle latency when empty.
- Not defined: no comb path from if_packet_in to id_packet_out; minimum latency 1 cycle.

Decomposition:
- Shared package/sys_defs.svh: `INST_BUF_DEPTH default constant; IF_ID_PACKET (existing).
- A small generic sub-module, fifo_ptr (pointer increment with wrap plus occupancy counter), is natural and reusable for the LSQ/ROB. Storage and bypass logic stay in inst_buffer.

Test Plan:
- Reset, then 3 enqueues (PC 0x0, 0x4, 0x8), out_ready=0 -> count=3, output PC=0x0 valid=1; then out_ready=1 for 3 cycles -> outputs 0x0, 0x4, 0x8 in order, count back to 0, valid=0.
- Fill to DEPTH=8 with out_ready=0 -> in_ready=0 at count=8. A 9th packet (PC 0x20) is held by fetch and not lost. One dequeue -> in_ready=1, 0x20 accepted next cycle, count=8.
- Steady stream, enq & deq every cycle for 20 cycles with pointers wrapping past DEPTH -> count constant, output PC sequence contiguous, no gaps or duplicates.
- count=5, assert squash with if_packet_in.valid=1 and out_ready=1 -> output valid=0 that cycle; next cycle count=0 and the squash-cycle packet is not stored.
- Assert reset at count=4 -> next cycle count=0, in_ready=1, valid=0; a subsequent enqueue of PC 0x100 emerges first.
- INST_BUF_BYPASS_EN, empty buffer, enqueue PC 0x40 with out_ready=1 -> 0x40 at output same cycle, count stays 0. Without the macro -> 0x40 appears the next cycle, count=1 then 0.
